// File: rtl/servo_pwm.sv
// Two-channel servo PWM generator with a one-deep command buffer.
// Commands are latched on accept and only applied at the period wrap.
module servo_pwm #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MID_CYCLES    = 75000,
  parameter int unsigned SCALE         = 195,
  parameter int unsigned CW            = $clog2(PERIOD_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] speed_l,
  input  logic [7:0] speed_r,
  input  logic       enable,
  output logic [1:0] servo,
  output logic       period_start
);

  localparam int unsigned WW = CW + 9;
  localparam logic signed [WW-1:0] MID_S   = WW'(MID_CYCLES);
  localparam logic signed [WW-1:0] SCALE_S = WW'(SCALE);
  localparam logic [CW-1:0]        LAST    = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0]        MID_W   = CW'(MID_CYCLES);

  if ((MID_CYCLES <= 127 * SCALE) || (MID_CYCLES + 127 * SCALE >= PERIOD_CYCLES)) begin : g_param_check
    $error("servo_pwm: MID_CYCLES +/- 127*SCALE must lie strictly inside (0, PERIOD_CYCLES)");
  end

  // Legal parameters keep the result in (0, PERIOD_CYCLES), so the low CW bits are exact.
  function automatic logic [CW-1:0] f_width(input logic [7:0] spd);
    logic signed [7:0]    s;
    logic signed [WW-1:0] w;
    s = (spd == 8'h80) ? 8'sh81 : signed'(spd);
    w = MID_S + WW'(s) * SCALE_S;
    return w[CW-1:0];
  endfunction

  logic [CW-1:0] r_cnt;
  logic          r_pend_valid;
  logic [CW-1:0] r_pend_l;
  logic [CW-1:0] r_pend_r;
  logic [CW-1:0] r_act_l;
  logic [CW-1:0] r_act_r;
  logic          r_act_en;
  logic [1:0]    r_servo;
  logic          r_period_start;

  logic w_load;
  logic w_accept;

  always_comb begin
    w_load   = (r_cnt == LAST);
    w_accept = cmd_valid && !r_pend_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_l       <= MID_W;
      r_pend_r       <= MID_W;
      r_act_l        <= MID_W;
      r_act_r        <= MID_W;
      r_act_en       <= 1'b0;
      r_servo        <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_load ? '0 : r_cnt + 1'b1;
      r_period_start <= (r_cnt == '0);
      r_servo[0]     <= r_act_en && (r_cnt < r_act_l);
      r_servo[1]     <= r_act_en && (r_cnt < r_act_r);
      if (w_load) begin
        r_act_en <= enable;
        if (r_pend_valid) begin
          r_act_l      <= r_pend_l;
          r_act_r      <= r_pend_r;
          r_pend_valid <= 1'b0;
        end
      end
      // An accept on the load edge only happens with the buffer empty, so it never races the clear above.
      if (w_accept) begin
        r_pend_l     <= f_width(speed_l);
        r_pend_r     <= f_width(speed_r);
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign cmd_ready    = !r_pend_valid;
  assign servo        = r_servo;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with a scaled-down period; an edge-count model
// checks every cycle and per-period pulse widths are checked against literals.
module tb_servo_pwm;

  localparam int P   = 1000;
  localparam int MID = 500;
  localparam int SC  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] speed_l;
  logic [7:0] speed_r;
  logic       enable;
  logic [1:0] servo;
  logic       period_start;

  int n_vec = 0;
  int n_err = 0;

  servo_pwm #(
    .PERIOD_CYCLES(P),
    .MID_CYCLES   (MID),
    .SCALE        (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .speed_l     (speed_l),
    .speed_r     (speed_r),
    .enable      (enable),
    .servo       (servo),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Model: edges since reset, the period each edge belongs to, and the
  // configuration (enable, widths) fixed for that period at its boundary.
  int   m_edges;
  bit   m_live = 1'b0;
  bit   m_pend;
  int   m_pl, m_pr;
  int   m_wl, m_wr;
  bit   m_en;
  logic [1:0] exp_servo;
  logic       exp_ps;
  logic       exp_ready;

  function automatic int m_width(input int spd);
    int s;
    s = (spd < -127) ? -127 : spd;
    return MID + s * SC;
  endfunction

  always @(posedge clk) begin
    int ph;
    bit take;
    m_live = 1'b1;
    if (reset) begin
      m_edges   = 0;
      m_pend    = 1'b0;
      m_en      = 1'b0;
      m_wl      = MID;
      m_wr      = MID;
      exp_servo = 2'b00;
      exp_ps    = 1'b0;
    end else begin
      ph        = m_edges % P;
      exp_ps    = (ph == 0);
      exp_servo = {m_en && (ph < m_wr), m_en && (ph < m_wl)};
      take      = cmd_valid && !m_pend;
      if (ph == P - 1) begin
        m_en = enable;
        if (m_pend) begin
          m_wl   = m_pl;
          m_wr   = m_pr;
          m_pend = 1'b0;
        end
      end
      if (take) begin
        m_pl   = m_width(int'(signed'(speed_l)));
        m_pr   = m_width(int'(signed'(speed_r)));
        m_pend = 1'b1;
      end
      m_edges++;
    end
    exp_ready = !m_pend;
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_vec++;
      if ({servo, period_start, cmd_ready} !== {exp_servo, exp_ps, exp_ready}) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL cycle_cmp t=%0t: servo=%b ps=%b ready=%b, expected servo=%b ps=%b ready=%b",
                   $time, servo, period_start, cmd_ready, exp_servo, exp_ps, exp_ready);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync(input string name);
    int k = 0;
    while (period_start !== 1'b1 && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(period_start === 1'b1), 1);
  endtask

  // Starts on a period_start sample, counts high cycles over one period,
  // and leaves the caller on the next period_start sample.
  task automatic measure(input int exp_l, input int exp_r, input string name);
    int hl = 0;
    int hr = 0;
    check({name, "_ps"}, int'(period_start), 1);
    for (int i = 0; i < P; i++) begin
      if (servo[0]) hl++;
      if (servo[1]) hr++;
      @(negedge clk);
    end
    check({name, "_wl"}, hl, exp_l);
    check({name, "_wr"}, hr, exp_r);
  endtask

  task automatic send(input int l, input int r);
    speed_l   = 8'(l);
    speed_r   = 8'(r);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    speed_l   = '0;
    speed_r   = '0;
    enable    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_servo", int'(servo), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_ps", int'(period_start), 0);
    reset = 1'b0;
    sync("sync_boot");

    measure(0, 0, "p0_first_after_reset");
    measure(MID, MID, "p1_default");

    fork
      measure(MID, MID, "p2_old");
      send(100, -127);
    join
    measure(800, 119, "p3_cmd");

    fork
      measure(800, 119, "p4_old");
      send(-128, -127);
    join
    measure(119, 119, "p5_neg128");

    // Back-pressure: valid held for two periods with data changing every cycle.
    fork
      begin
        measure(119, 119, "p6_bp");
        measure(350, 650, "p7_bp");
        measure(620, 380, "p8_bp");
      end
      begin
        for (int j = 0; j < 2 * P; j++) begin
          speed_l   = 8'(j % 101 - 50);
          speed_r   = 8'(50 - j % 101);
          cmd_valid = 1'b1;
          @(negedge clk);
          if (j == 1) check("bp_ready_low", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
      end
    join
    measure(590, 410, "p9_bp");

    // Accept exactly on the load edge.
    fork
      measure(590, 410, "p10_loadacc");
      begin
        repeat (P - 2) @(negedge clk);
        check("loadacc_ready_before", int'(cmd_ready), 1);
        send(127, 0);
        check("loadacc_ready_after", int'(cmd_ready), 0);
      end
    join
    measure(590, 410, "p11_still_old");
    check("ready_after_load", int'(cmd_ready), 1);
    measure(881, 500, "p12_new");

    fork
      measure(881, 500, "p13_en_drop");
      begin repeat (100) @(negedge clk); enable = 1'b0; end
    join
    fork
      measure(0, 0, "p14_disabled");
      begin repeat (500) @(negedge clk); enable = 1'b1; end
    join
    measure(881, 500, "p15_resumed");

    // Reset mid-pulse with a command pending.
    send(-127, -127);
    repeat (9) @(negedge clk);
    check("pre_reset_servo", int'(servo), 3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_servo", int'(servo), 0);
    check("midreset_ready", int'(cmd_ready), 1);
    check("midreset_ps", int'(period_start), 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    sync("sync_after_reset");
    measure(0, 0, "r0_no_pulse");
    measure(MID, MID, "r1_pending_discarded");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
